led_mode_ctrl: RTL

//  Mode controller sequencing the board LED from one debounced push-button.

---
 rtl/led_mode_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - LED mode sequencer driven by a debounced push-button
module led_mode_ctrl #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int LONG_PRESS_MS = 1000,
    parameter int SLOW_HALF_MS  = 500,
    parameter int FAST_HALF_MS  = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_clean_i,
    output logic       led_o,
    output logic [1:0] mode_o,
    output logic       long_press_o
);

    localparam int LONG_CYC  = CLK_FREQ / 1000 * LONG_PRESS_MS;
    localparam int SLOW_CYC  = CLK_FREQ / 1000 * SLOW_HALF_MS;
    localparam int FAST_CYC  = CLK_FREQ / 1000 * FAST_HALF_MS;
    localparam int HOLD_W    = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
    localparam int BLINK_MAX = (SLOW_CYC > FAST_CYC) ? SLOW_CYC : FAST_CYC;
    localparam int BLINK_W   = (BLINK_MAX > 1) ? $clog2(BLINK_MAX) : 1;

    generate
        if (LONG_CYC < 2 || SLOW_CYC < 1 || FAST_CYC < 1) begin : g_bad_params
            $error("led_mode_ctrl: timing parameters give LONG_CYC<2 or a zero blink half-period");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG_DONE} press_state_t;
    typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_SLOW, MODE_FAST} mode_t;

    press_state_t       state_q;
    mode_t              mode_q;
    mode_t              mode_nxt;
    logic               btn_prev;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               led_q;
    logic               long_q;

    logic btn_press;
    logic btn_rel;
    logic long_evt;
    logic short_evt;
    logic blink_last;
    logic in_blink;

    assign btn_press = btn_prev & ~btn_clean_i;
    assign btn_rel   = ~btn_prev & btn_clean_i;

    // Threshold beats a simultaneous release, so a long press is never seen as short.
    assign long_evt  = (state_q == ST_HELD) && (hold_cnt == HOLD_W'(LONG_CYC - 1));
    assign short_evt = (state_q == ST_HELD) && !long_evt && btn_rel;

    assign in_blink   = (mode_q == MODE_SLOW) || (mode_q == MODE_FAST);
    assign blink_last = (mode_q == MODE_SLOW) ? (blink_cnt == BLINK_W'(SLOW_CYC - 1))
                                              : (blink_cnt == BLINK_W'(FAST_CYC - 1));

    always_comb begin
        mode_nxt = mode_q;
        if (long_evt) begin
            mode_nxt = MODE_OFF;
        end else if (short_evt) begin
            mode_nxt = mode_t'(mode_q + 2'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_OFF;
            btn_prev  <= 1'b1;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            led_q     <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            btn_prev <= btn_clean_i;
            long_q   <= long_evt;
            mode_q   <= mode_nxt;

            case (state_q)
                ST_IDLE: begin
                    if (btn_press) begin
                        state_q  <= ST_HELD;
                        hold_cnt <= HOLD_W'(1);
                    end
                end
                ST_HELD: begin
                    if (long_evt) begin
                        state_q <= btn_rel ? ST_IDLE : ST_LONG_DONE;
                    end else if (btn_rel) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_LONG_DONE: begin
                    if (btn_rel) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Any mode change restarts the blink phase with the LED lit.
            if (mode_nxt != mode_q) begin
                blink_cnt <= '0;
                led_q     <= (mode_nxt != MODE_OFF);
            end else if (in_blink) begin
                if (blink_last) begin
                    led_q     <= ~led_q;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end else begin
                blink_cnt <= '0;
            end
        end
    end

    assign led_o        = led_q;
    assign mode_o       = mode_q;
    assign long_press_o = long_q;

endmodule
